// File: rtl/stable_run_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stable_run_pkg                                                |
// | Purpose  : Shared types and defaults for the stable-run logger slice.    |
// |            run_state_t  - run detector FSM state                         |
// |            run_rec_t    - one run record {len, sat} at default width     |
// |            c_CNT_W      - default run-length counter width               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package stable_run_pkg;

   localparam int c_CNT_W = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } run_state_t;

   // Record layout as stored in the FIFO: length in the upper bits, the
   // saturation flag in bit 0.
   typedef struct packed {
      logic [c_CNT_W-1:0] len;
      logic               sat;
   } run_rec_t;

endpackage : stable_run_pkg
`default_nettype wire

// File: rtl/run_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : run_fifo                                                      |
// | Purpose  : Synchronous FIFO with a registered head word. A push while    |
// |            full is accepted only when a pop happens on the same edge.    |
// | Ports    : clk, reset (sync, active high)                                |
// |            push / din   - write request and data                         |
// |            pop          - read request (ignored while empty)             |
// |            dout         - head word, 0 while empty                       |
// |            full, empty  - occupancy flags                                |
// |            level        - occupancy 0..DEPTH                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module run_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_LW = c_PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_PW-1:0]  r_wr_ptr;
   logic [c_PW-1:0]  r_rd_ptr;
   logic [c_LW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_head;

   logic             w_rd_en;
   logic             w_wr_en;
   logic [c_PW-1:0]  w_rd_nxt;
   logic [c_LW-1:0]  w_cnt_nxt;

   assign empty    = (r_cnt == '0);
   assign full     = (r_cnt == c_LW'(DEPTH));
   assign w_rd_en  = pop & ~empty;
   // A full FIFO still takes a write when the head leaves on the same edge.
   assign w_wr_en  = push & (~full | w_rd_en);
   assign w_rd_nxt = r_rd_ptr + 1'b1;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_wr_en && !w_rd_en)
         w_cnt_nxt = r_cnt + 1'b1;
      else if (w_rd_en && !w_wr_en)
         w_cnt_nxt = r_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_head   <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_wr_en)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en)
            r_rd_ptr <= w_rd_nxt;
         // Head tracks what will sit at the read pointer after this edge.
         // The incoming word becomes head only when nothing older remains.
         if (w_cnt_nxt == '0)
            r_head <= '0;
         else if (w_wr_en && ((r_cnt == '0) || (w_rd_en && r_cnt == c_LW'(1))))
            r_head <= din;
         else if (w_rd_en)
            r_head <= r_mem[w_rd_nxt];
      end
   end

   assign dout  = r_head;
   assign level = r_cnt;

endmodule : run_fifo
`default_nettype wire

// File: rtl/stable_run_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stable_run_logger                                             |
// | Purpose  : Measures runs of consecutive douty=1 cycles and queues one    |
// |            {length, saturated} record per run of at least MIN_RUN        |
// |            cycles for a valid/ready consumer.                            |
// | Ports    : clk, reset (sync, active high)                                |
// |            doutx, douty       - stability flags from the detector        |
// |            rec_valid/ready    - record handshake                         |
// |            rec_len, rec_sat   - head record (0 while empty)              |
// |            level              - FIFO occupancy                           |
// |            overflow           - sticky, record dropped on full FIFO      |
// |            err                - sticky, douty seen without doutx         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module stable_run_logger
   import stable_run_pkg::*;
#(
   parameter int CNT_W   = c_CNT_W,
   parameter int DEPTH   = 4,
   parameter int MIN_RUN = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       doutx,
   input  logic                       douty,
   output logic                       rec_valid,
   input  logic                       rec_ready,
   output logic [CNT_W-1:0]           rec_len,
   output logic                       rec_sat,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic                       err
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_MIN_RUN = CNT_W'(MIN_RUN);

   run_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;
   logic             r_overflow;
   logic             r_err;

   logic             w_y_eff;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W:0]   w_din;
   logic [CNT_W:0]   w_dout;

   // douty without doutx is an upstream fault and never counts as stable.
   assign w_y_eff = douty & doutx;
   assign w_push  = (r_state == RUN) && !w_y_eff && (r_cnt >= c_MIN_RUN);
   assign w_pop   = rec_valid & rec_ready;
   assign w_din   = {r_cnt, r_sat};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_sat      <= 1'b0;
         r_overflow <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (douty && !doutx)
            r_err <= 1'b1;
         if (w_push && w_full && !w_pop)
            r_overflow <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_y_eff) begin
                  r_state <= RUN;
                  r_cnt   <= CNT_W'(1);
                  r_sat   <= 1'b0;
               end
            end
            RUN: begin
               if (w_y_eff) begin
                  if (r_cnt == c_CNT_MAX)
                     r_sat <= 1'b1;
                  else
                     r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   run_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CNT_W + 1)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_din),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );

   assign rec_valid = ~w_empty;
   assign rec_len   = w_dout[CNT_W:1];
   assign rec_sat   = w_dout[0];
   assign overflow  = r_overflow;
   assign err       = r_err;

endmodule : stable_run_logger
`default_nettype wire

// File: tb/tb_stable_run_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_stable_run_logger                                          |
// | Purpose  : Directed bench for stable_run_logger with hand-computed       |
// |            expected records, FIFO levels and sticky flags.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_stable_run_logger;

   logic       clk = 1'b0;
   logic       reset;
   logic       doutx;
   logic       douty;
   logic       rec_valid;
   logic       rec_ready;
   logic [7:0] rec_len;
   logic       rec_sat;
   logic [2:0] level;
   logic       overflow;
   logic       err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stable_run_logger #(
      .CNT_W   (8),
      .DEPTH   (4),
      .MIN_RUN (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .doutx     (doutx),
      .douty     (douty),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_len   (rec_len),
      .rec_sat   (rec_sat),
      .level     (level),
      .overflow  (overflow),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_y(input logic x, input logic y);
      doutx = x;
      douty = y;
   endtask

   // Run of len stable cycles followed by the closing zero sample.
   task automatic run(input int len);
      set_y(1'b1, 1'b1);
      step(len);
      set_y(1'b0, 1'b0);
      step(1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"},    32'(rec_valid), 0);
      check({tag, "_len"},      32'(rec_len),   0);
      check({tag, "_sat"},      32'(rec_sat),   0);
      check({tag, "_level"},    32'(level),     0);
   endtask

   initial begin
      reset     = 1'b1;
      rec_ready = 1'b0;
      set_y(1'b0, 1'b0);
      step(1);
      do_reset();
      check_idle("rst");
      check("rst_ovf", 32'(overflow), 0);
      check("rst_err", 32'(err), 0);

      // Single run of 5 with consumer ready.
      rec_ready = 1'b1;
      set_y(1'b1, 1'b1);
      step(5);
      check("r5_no_early", 32'(rec_valid), 0);
      set_y(1'b0, 1'b0);
      step(1);
      check("r5_valid", 32'(rec_valid), 1);
      check("r5_len",   32'(rec_len),   5);
      check("r5_sat",   32'(rec_sat),   0);
      check("r5_level", 32'(level),     1);
      step(1);
      check_idle("r5_pop");

      // 1-cycle run is discarded; 2-cycle run after a single gap is kept.
      rec_ready = 1'b0;
      run(1);
      check("short_level", 32'(level), 0);
      run(2);
      step(1);
      check("r2_level", 32'(level),   1);
      check("r2_len",   32'(rec_len), 2);
      rec_ready = 1'b1;
      step(1);
      check("r2_pop_level", 32'(level), 0);

      // Saturating run, then a normal run of 3.
      rec_ready = 1'b0;
      run(300);
      check("sat_len", 32'(rec_len), 255);
      check("sat_sat", 32'(rec_sat), 1);
      rec_ready = 1'b1;
      step(1);
      rec_ready = 1'b0;
      run(3);
      check("post_sat_len", 32'(rec_len), 3);
      check("post_sat_sat", 32'(rec_sat), 0);
      rec_ready = 1'b1;
      step(1);
      check("post_sat_level", 32'(level), 0);

      // Overflow: five back-to-back runs into a depth-4 FIFO.
      rec_ready = 1'b0;
      for (int k = 3; k <= 6; k++) run(k);
      check("fill_level", 32'(level),    4);
      check("fill_ovf",   32'(overflow), 0);
      run(7);
      check("ovf_level", 32'(level),    4);
      check("ovf_flag",  32'(overflow), 1);
      step(1);
      check("hold_len", 32'(rec_len), 3);
      rec_ready = 1'b1;
      for (int k = 4; k <= 6; k++) begin
         step(1);
         check($sformatf("drain_len%0d", k), 32'(rec_len), 32'(k));
      end
      step(1);
      check("drain_level", 32'(level), 0);
      check("drain_ovf",   32'(overflow), 1);

      // Push and pop on the same edge while full.
      do_reset();
      rec_ready = 1'b0;
      for (int k = 2; k <= 5; k++) run(k);
      check("pp_full", 32'(level), 4);
      set_y(1'b1, 1'b1);
      step(6);
      set_y(1'b0, 1'b0);
      rec_ready = 1'b1;
      step(1);
      check("pp_level", 32'(level),    4);
      check("pp_ovf",   32'(overflow), 0);
      check("pp_head",  32'(rec_len),  3);
      for (int k = 4; k <= 6; k++) begin
         step(1);
         check($sformatf("pp_len%0d", k), 32'(rec_len), 32'(k));
      end
      step(1);
      check("pp_empty", 32'(level), 0);

      // Reset mid-run discards the run; douty without doutx flags err only.
      rec_ready = 1'b0;
      set_y(1'b1, 1'b1);
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      set_y(1'b0, 1'b0);
      step(1);
      check_idle("mid_rst");
      check("mid_rst_ovf", 32'(overflow), 0);
      check("mid_rst_err", 32'(err), 0);
      set_y(1'b0, 1'b1);
      step(2);
      set_y(1'b0, 1'b0);
      step(2);
      check("err_flag",  32'(err),   1);
      check("err_level", 32'(level), 0);
      check("err_valid", 32'(rec_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_stable_run_logger
`default_nettype wire
